// File: rtl/sb_msg_issuer.sv
// Sideband message issuer: queues LTSM message words and issues them one at a time
// to the sideband serializer using a valid-pulse / busy-response handshake.
module sb_msg_issuer #(
  parameter int MSG_W        = 16,
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 8,
  parameter int GAP_CYCLES   = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  input  logic [MSG_W-1:0]           req_msg,
  output logic                       req_ready,
  input  logic                       flush,
  output logic                       sb_valid,
  output logic [MSG_W-1:0]           sb_msg,
  input  logic                       sb_busy,
  output logic                       msg_sent,
  output logic                       timeout_err,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int CW      = $clog2(DEPTH + 1);
  localparam int PW      = $clog2(DEPTH);
  localparam int CNT_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] BT_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  // Handshake: sb_valid is a single-cycle pulse with sb_msg valid alongside it; the
  // serializer answers by raising sb_busy and the word is complete when busy falls.
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [MSG_W-1:0]   sb_msg_q, sb_msg_d;
  logic               sb_valid_q, sb_valid_d;
  logic               msg_sent_q, msg_sent_d;
  logic               timeout_err_q, timeout_err_d;
  logic [MSG_W-1:0]   mem_q [DEPTH];
  logic               push, pop;

  assign req_ready   = (count_q != CW'(DEPTH));
  assign push        = req_valid && req_ready && !flush;
  assign sb_valid    = sb_valid_q;
  assign sb_msg      = sb_msg_q;
  assign msg_sent    = msg_sent_q;
  assign timeout_err = timeout_err_q;
  assign fifo_count  = count_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sb_msg_d      = sb_msg_q;
    sb_valid_d    = 1'b0;
    msg_sent_d    = 1'b0;
    timeout_err_d = 1'b0;
    pop           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0 && !flush) begin
          pop        = 1'b1;
          sb_msg_d   = mem_q[rd_ptr_q];
          sb_valid_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (sb_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == BT_LAST) begin
          timeout_err_d = 1'b1;
          cnt_d         = '0;
          state_d       = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!sb_busy) begin
          msg_sent_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Flush only clears the queue; an in-flight word keeps running to completion.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      sb_msg_q      <= '0;
      sb_valid_q    <= 1'b0;
      msg_sent_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      sb_msg_q      <= sb_msg_d;
      sb_valid_q    <= sb_valid_d;
      msg_sent_q    <= msg_sent_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= req_msg;
  end

endmodule

// File: doc/sb_msg_issuer.md
Name: sb_msg_issuer

Overview:
- Initiator side of the sideband valid/busy handshake used by the LTSM substates (MBINIT and others).
- LTSM substates push sideband message words into a small FIFO. The block issues the words one at a time to the sideband serializer as a one-cycle valid pulse.
- It tracks the serializer's busy response and enforces a quiet gap after busy falls, so the serializer is never re-armed while it is still settling.
- It reports per-message completion or timeout back to the LTSM.

Parameters:
MSG_W, 16, width of one sideband message word (msg code + info)
DEPTH, 4, FIFO depth in words (power of 2, >=2)
BUSY_TIMEOUT, 8, max cycles to wait in WAIT_BUSY for sb_busy to rise
GAP_CYCLES, 6, idle cycles enforced after busy falls (or after timeout) before the next issue

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  push request from LTSM
req_msg  in  MSG_W  message word to push
req_ready  out  1  FIFO not full (combinational from count)
flush  in  1  synchronous FIFO clear
sb_valid  out  1  one-cycle issue pulse to serializer
sb_msg  out  MSG_W  issued word; held stable from the sb_valid cycle until the next issue
sb_busy  in  1  serializer busy
msg_sent  out  1  one-cycle pulse when busy falls for the in-flight word
timeout_err  out  1  one-cycle pulse when busy never rose
fifo_count  out  $clog2(DEPTH+1)  words queued

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; FIFO empty; counter = 0.
  - sb_valid = 0, sb_msg = 0, msg_sent = 0, timeout_err = 0, fifo_count = 0, req_ready = 1.
- FIFO:
  - Push when req_valid && req_ready.
  - Push when full is ignored; contents and count are unchanged.
  - Push and pop in the same cycle: both occur; count is unchanged. A push into an empty FIFO is not visible to the FSM until the next cycle.
  - Pointers wrap modulo DEPTH.
- flush:
  - Clears pointers and count next cycle.
  - Flush wins over a simultaneous push and pop: no pop and no sb_valid that cycle.
  - Does not abort the in-flight word; the FSM continues its current transaction.
- FSM states and transitions (all outputs registered):
  - IDLE: if fifo_count>0 and !flush, pop the head, load sb_msg, assert sb_valid next cycle, go to ISSUE.
  - ISSUE (1 cycle, sb_valid=1): sb_busy is ignored this cycle. Clear counter, go to WAIT_BUSY.
  - WAIT_BUSY:
    - If sb_busy=1, go to WAIT_DONE.
    - Else counter++. When counter == BUSY_TIMEOUT-1 and sb_busy=0, pulse timeout_err, drop the word, go to GAP.
  - WAIT_DONE: stay while sb_busy=1. On sb_busy=0, pulse msg_sent (registered, the cycle after busy is seen low), clear counter, go to GAP.
  - GAP: counter++. When counter == GAP_CYCLES-1, go to IDLE. No issue is made in GAP even if the FIFO is non-empty.
  - Illegal state encodings recover to IDLE.
- Latency and throughput:
  - First sb_valid occurs 2 cycles after a push into an empty idle block (push registers, then IDLE decides, then sb_valid).
  - With the serializer holding busy for B cycles, back-to-back spacing is 1 + 1 + B + GAP_CYCLES + 1 cycles between sb_valid pulses.
- Exclusivity and simultaneous events:
  - msg_sent and timeout_err are mutually exclusive and never both pulse for one word.
  - sb_busy high while in IDLE or GAP is ignored.
- Reset mid-transaction: all state is discarded immediately; no pulses are emitted on reset exit.

Test Plan:
- Single message: push 16'hA55A into an idle block; serializer busy high 5 cycles starting the cycle after sb_valid -> one sb_valid pulse with sb_msg=16'hA55A, msg_sent pulse exactly once, fifo_count returns to 0, and no new sb_valid for 6 cycles after msg_sent.
- Back-to-back: push 16'h0001..16'h0004 on consecutive cycles -> req_ready=0 after the 4th push if none has yet popped. Four sb_valid pulses occur in order 1,2,3,4, each separated by at least GAP_CYCLES idle cycles after busy falls, with four msg_sent pulses.
- Overflow: push 5 words while the serializer holds busy indefinitely -> 5th push dropped, fifo_count saturates at 4 minus words already popped, and no corruption of queued data.
- Timeout: push 16'h1234 with sb_busy tied 0 -> timeout_err pulses 8 cycles after entering WAIT_BUSY, no msg_sent, then 6 GAP cycles, and the next queued word issues normally.
- Flush: queue 3 words, assert flush during WAIT_DONE of word 1 -> word 1 completes with msg_sent, words 2-3 never issue, fifo_count=0. Flush together with a push leaves the FIFO empty.
- Async reset: assert rst_n=0 mid-WAIT_DONE -> all outputs 0 immediately, req_ready=1, and no msg_sent after release.
